// File: rtl/vlc_4b6b_tx_framer.sv
// VLC transmit framer: byte stream -> preamble + SFD + 4B6B-coded nibbles, MSB-first, CLKS_PER_BIT clocks per bit.
// One-byte holding register decouples the source handshake from the serializer.
// state    | meaning
// S_IDLE   | line quiet, waiting for a byte in the holding register
// S_PRE    | alternating 1,0 preamble
// S_SFD    | start-of-frame delimiter
// S_HI     | code of the high nibble
// S_LO     | code of the low nibble, decides continue / end / underrun
// S_END    | one quiet cycle carrying the frame_done or underrun pulse
module vlc_4b6b_tx_framer #(
    parameter int          CLKS_PER_BIT  = 16,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [5:0]  SFD           = 6'b111000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       abort,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int TW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BMAX = (PREAMBLE_BITS > 6) ? PREAMBLE_BITS : 6;
    localparam int BCW  = $clog2(BMAX);
    localparam logic [TW-1:0]  T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] PRE_LAST = BCW'(PREAMBLE_BITS - 1);
    localparam logic [BCW-1:0] COD_LAST = BCW'(5);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_HI, S_LO, S_END} state_t;

    state_t         state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [BCW-1:0] bitcnt, bitcnt_n;
    logic [7:0]     cur_byte, byte_n, hold_data;
    logic           cur_last, last_n, hold_last;
    logic           hold_full, hold_full_n;
    logic           tx_bit_n, tx_en_n, fd_n, ur_n;
    logic           load, accept, bit_end, last_bit, on_line_n;
    logic [5:0]     code;
    logic [2:0]     sel;

    function automatic logic [5:0] enc4b6b(input logic [3:0] n);
        case (n)
            4'h0: enc4b6b = 6'b001110;  4'h1: enc4b6b = 6'b001101;
            4'h2: enc4b6b = 6'b010011;  4'h3: enc4b6b = 6'b010110;
            4'h4: enc4b6b = 6'b010101;  4'h5: enc4b6b = 6'b100011;
            4'h6: enc4b6b = 6'b100110;  4'h7: enc4b6b = 6'b100101;
            4'h8: enc4b6b = 6'b011001;  4'h9: enc4b6b = 6'b011010;
            4'hA: enc4b6b = 6'b011100;  4'hB: enc4b6b = 6'b110001;
            4'hC: enc4b6b = 6'b110010;  4'hD: enc4b6b = 6'b101001;
            4'hE: enc4b6b = 6'b101010;  default: enc4b6b = 6'b101100;
        endcase
    endfunction

    assign s_ready  = !hold_full;
    assign busy     = (state != S_IDLE) || hold_full;
    assign accept   = s_valid && !hold_full && !abort;
    assign bit_end  = (timer == T_LAST);
    assign last_bit = bit_end && (bitcnt == ((state == S_PRE) ? PRE_LAST : COD_LAST));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        fd_n    = 1'b0;
        ur_n    = 1'b0;
        case (state)
            S_IDLE: if (hold_full) state_n = S_PRE;
            S_PRE:  if (last_bit) state_n = S_SFD;
            S_SFD:  if (last_bit) begin state_n = S_HI; load = 1'b1; end
            S_HI:   if (last_bit) state_n = S_LO;
            S_LO: begin
                if (last_bit) begin
                    if (cur_last) begin
                        state_n = S_END;
                        fd_n    = 1'b1;
                    end else if (hold_full) begin
                        state_n = S_HI;
                        load    = 1'b1;
                    end else begin
                        state_n = S_END;
                        ur_n    = 1'b1;
                    end
                end
            end
            S_END:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            load    = 1'b0;
            fd_n    = 1'b0;
            ur_n    = 1'b0;
        end

        on_line_n = (state_n == S_PRE) || (state_n == S_SFD) || (state_n == S_HI) || (state_n == S_LO);
        timer_n   = '0;
        bitcnt_n  = '0;
        if (state_n == state && on_line_n) begin
            if (bit_end) bitcnt_n = bitcnt + 1'b1;
            else begin
                bitcnt_n = bitcnt;
                timer_n  = timer + 1'b1;
            end
        end

        byte_n      = load ? hold_data : cur_byte;
        last_n      = load ? hold_last : cur_last;
        hold_full_n = abort ? 1'b0 : (accept ? 1'b1 : (load ? 1'b0 : hold_full));

        // Line bit is derived from where the serializer will be next cycle
        sel  = 3'd5 - bitcnt_n[2:0];
        code = SFD;
        if (state_n == S_HI) code = enc4b6b(byte_n[7:4]);
        if (state_n == S_LO) code = enc4b6b(byte_n[3:0]);
        tx_en_n  = on_line_n;
        tx_bit_n = 1'b0;
        if (state_n == S_PRE) tx_bit_n = ~bitcnt_n[0];
        else if (on_line_n)   tx_bit_n = code[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            cur_byte   <= '0;
            cur_last   <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bitcnt     <= bitcnt_n;
            cur_byte   <= byte_n;
            cur_last   <= last_n;
            hold_full  <= hold_full_n;
            tx_bit     <= tx_bit_n;
            tx_en      <= tx_en_n;
            frame_done <= fd_n;
            underrun   <= ur_n;
            if (accept) begin
                hold_data <= s_data;
                hold_last <= s_last;
            end
        end
    end

endmodule
